// File: rtl/pp_serial_mac.sv
// pp_serial_mac: bit-serial sign-magnitude MAC. It produces one shifted partial
// product per clock from the weight magnitude bits and accumulates KERNEL_LEN
// (image, weight) pairs into a saturating signed sum.
module pp_serial_mac #(
  parameter int unsigned IMG_W      = 8,
  parameter int unsigned WGT_W      = 4,
  parameter int unsigned KERNEL_LEN = 9,
  parameter int unsigned ACC_W      = 16,
  parameter int unsigned SKIP_ZERO  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IMG_W-1:0]        image,
  input  logic [WGT_W-1:0]        weight,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic                    out_overflow,
  output logic                    busy
);

  localparam int unsigned MAG_W = WGT_W - 1;
  localparam int unsigned IDX_W = (MAG_W > 1) ? $clog2(MAG_W) : 1;
  localparam int unsigned CNT_W = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
  localparam int unsigned PP_W  = IMG_W + MAG_W - 1;
  // The sum is one bit wider than both operands, so it cannot wrap before the clamp.
  localparam int unsigned SUM_W = ((ACC_W > PP_W + 1) ? ACC_W : PP_W + 1) + 1;

  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_OUT} state_t;

  state_t                  state, state_d;
  logic [IMG_W-1:0]        img_q, img_d;
  logic                    sign_q, sign_d;
  logic [MAG_W-1:0]        mask_q, mask_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] sum_d;
  logic                    ovf_d;
  logic                    in_ready_d, out_valid_d, busy_d;

  logic [IDX_W-1:0]        low_idx;
  logic [IDX_W-1:0]        sel_idx;
  logic                    bit_on;
  logic                    pair_end;
  logic [MAG_W-1:0]        mask_clr;
  logic signed [SUM_W-1:0] pp_mag, pp, acc_ext, raw_sum;
  logic signed [ACC_W-1:0] sat_sum;
  logic                    clamp;

  // Lowest set magnitude bit, used by the zero-skipping schedule.
  always_comb begin
    low_idx = '0;
    for (int i = int'(MAG_W) - 1; i >= 0; i--) begin
      if (mask_q[i]) low_idx = IDX_W'(i);
    end
  end

  // Partial-product selection and saturating accumulate for the current GEN cycle.
  always_comb begin
    mask_clr = mask_q & (mask_q - MAG_W'(1));
    if (SKIP_ZERO != 0) begin
      sel_idx  = low_idx;
      bit_on   = |mask_q;
      pair_end = (mask_clr == '0);
    end else begin
      sel_idx  = idx_q;
      bit_on   = mask_q[idx_q];
      pair_end = (idx_q == IDX_W'(MAG_W - 1));
    end
    pp_mag  = SUM_W'(img_q) << sel_idx;
    pp      = bit_on ? (sign_q ? -pp_mag : pp_mag) : '0;
    acc_ext = SUM_W'(acc_q);
    raw_sum = acc_ext + pp;
    clamp   = 1'b0;
    if (raw_sum > SAT_MAX) begin
      sat_sum = ACC_W'(SAT_MAX);
      clamp   = 1'b1;
    end else if (raw_sum < SAT_MIN) begin
      sat_sum = ACC_W'(SAT_MIN);
      clamp   = 1'b1;
    end else begin
      sat_sum = ACC_W'(raw_sum);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    img_d   = img_q;
    sign_d  = sign_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = out_sum;
    ovf_d   = out_overflow;
    unique case (state)
      S_IDLE: begin
        if (in_valid) begin
          img_d   = image;
          sign_d  = weight[WGT_W-1];
          mask_d  = weight[WGT_W-2:0];
          idx_d   = '0;
          state_d = S_GEN;
        end
      end
      S_GEN: begin
        acc_d = sat_sum;
        if (clamp) ovf_d = 1'b1;
        if (SKIP_ZERO != 0) mask_d = mask_clr;
        else                idx_d  = idx_q + IDX_W'(1);
        if (pair_end) begin
          if (cnt_q == CNT_W'(KERNEL_LEN - 1)) begin
            sum_d   = sat_sum;
            state_d = S_OUT;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_IDLE;
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_OUT);
    busy_d      = !((state_d == S_IDLE) && (cnt_d == '0));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      img_q        <= '0;
      sign_q       <= 1'b0;
      mask_q       <= '0;
      idx_q        <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      out_sum      <= '0;
      out_overflow <= 1'b0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      img_q        <= img_d;
      sign_q       <= sign_d;
      mask_q       <= mask_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      out_sum      <= sum_d;
      out_overflow <= ovf_d;
      in_ready     <= in_ready_d;
      out_valid    <= out_valid_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_pp_serial_mac.sv
// Directed bench for pp_serial_mac: default build, a 12-bit accumulator build
// and a fixed-schedule (SKIP_ZERO=0) build share one clock and reset.
module tb_pp_serial_mac;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  logic       iv   [3];
  logic [7:0] img  [3];
  logic [3:0] wgt  [3];
  logic       ordy [3];
  logic       irdy [3];
  logic       ov   [3];
  logic       oflw [3];
  logic       bsy  [3];
  logic signed [15:0] s0, s2;
  logic signed [11:0] s1;

  int vectors = 0;
  int errors  = 0;
  int last_acc = 0;
  int t0 = 0;

  always #5 clk = ~clk;

  // Free-running edge counter for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  pp_serial_mac u_def (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .image(img[0]),
    .weight(wgt[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(s0),
    .out_overflow(oflw[0]), .busy(bsy[0]));

  pp_serial_mac #(.ACC_W(12)) u_sat (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .image(img[1]),
    .weight(wgt[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(s1),
    .out_overflow(oflw[1]), .busy(bsy[1]));

  pp_serial_mac #(.SKIP_ZERO(0)) u_fix (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .image(img[2]),
    .weight(wgt[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(s2),
    .out_overflow(oflw[2]), .busy(bsy[2]));

  function automatic int sum_of(input int d);
    case (d)
      0:       return int'(s0);
      1:       return int'(s1);
      default: return int'(s2);
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one pair and wait (bounded) until it is accepted; in_valid stays high.
  task automatic send(input int d, input logic [7:0] im, input logic [3:0] w);
    int n;
    n = 0;
    img[d] = im;
    wgt[d] = w;
    iv[d]  = 1'b1;
    while (!irdy[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", int'(irdy[d]), 1);
    @(posedge clk);
    #1;
    last_acc = cyc;
  endtask

  // Wait for the kernel result, optionally hold off out_ready, then handshake.
  task automatic wait_out(input int d, input int exp_sum, input int exp_ovf,
                          input int exp_edges, input int hold, input bit present_next);
    int n;
    n = 0;
    iv[d] = 1'b0;
    while (!ov[d] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("out_valid_rise", int'(ov[d]), 1);
    if (exp_edges >= 0) chk("out_latency", cyc - t0, exp_edges);
    chk("out_sum", sum_of(d), exp_sum);
    chk("out_overflow", int'(oflw[d]), exp_ovf);
    chk("in_ready_in_out", int'(irdy[d]), 0);
    if (present_next) begin
      img[d] = 8'd1;
      wgt[d] = 4'b0001;
      iv[d]  = 1'b1;
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", int'(ov[d]), 1);
      chk("bp_out_sum", sum_of(d), exp_sum);
      chk("bp_in_ready", int'(irdy[d]), 0);
    end
    ordy[d] = 1'b1;
    @(posedge clk);
    #1;
    ordy[d] = 1'b0;
    chk("post_hs_out_valid", int'(ov[d]), 0);
    chk("post_hs_in_ready", int'(irdy[d]), 1);
    chk("post_hs_busy", int'(bsy[d]), 0);
    chk("post_hs_sum_hold", sum_of(d), exp_sum);
    chk("post_hs_overflow", int'(oflw[d]), 0);
  endtask

  task automatic basic_kernel(input int d);
    send(d, 8'hDA, 4'b1010);
    t0 = last_acc;
    send(d, 8'hAA, 4'b0011);
    for (int k = 0; k < 7; k++) send(d, 8'h00, 4'b0000);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; img[d] = '0; wgt[d] = '0; ordy[d] = 1'b0;
    end

    // Reset with random inputs on every build.
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      for (int d = 0; d < 3; d++) begin
        iv[d]   = 1'($urandom_range(0, 1));
        img[d]  = 8'($urandom);
        wgt[d]  = 4'($urandom);
        ordy[d] = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0;
    end
    for (int d = 0; d < 3; d++) begin
      chk("rst_in_ready", int'(irdy[d]), 1);
      chk("rst_out_valid", int'(ov[d]), 0);
      chk("rst_out_sum", sum_of(d), 0);
      chk("rst_overflow", int'(oflw[d]), 0);
      chk("rst_busy", int'(bsy[d]), 0);
    end

    // Basic kernel with latency check; busy is high mid-kernel.
    send(0, 8'hDA, 4'b1010);
    t0 = last_acc;
    chk("busy_gen", int'(bsy[0]), 1);
    send(0, 8'hAA, 4'b0011);
    for (int k = 0; k < 7; k++) send(0, 8'h00, 4'b0000);
    wait_out(0, 74, 0, 18, 0, 1'b0);

    // Backpressure: hold out_ready low 5 cycles with a pair waiting.
    basic_kernel(0);
    wait_out(0, 74, 0, 18, 5, 1'b1);
    for (int k = 0; k < 9; k++) send(0, 8'd1, 4'b0001);
    wait_out(0, 9, 0, -1, 0, 1'b0);

    // Saturation on the 12-bit build, then a clean kernel.
    for (int k = 0; k < 9; k++) send(1, 8'hFF, 4'b0111);
    wait_out(1, 2047, 1, -1, 0, 1'b0);
    for (int k = 0; k < 9; k++) send(1, 8'hFF, 4'b1111);
    wait_out(1, -2048, 1, -1, 0, 1'b0);
    for (int k = 0; k < 9; k++) send(1, 8'd1, 4'b0001);
    wait_out(1, 9, 0, -1, 0, 1'b0);

    // Reset while the fifth pair is in GEN.
    for (int k = 0; k < 5; k++) send(0, 8'd10, 4'b0001);
    chk("mid_busy", int'(bsy[0]), 1);
    iv[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_in_ready", int'(irdy[0]), 1);
    chk("mid_rst_busy", int'(bsy[0]), 0);
    chk("mid_rst_out_valid", int'(ov[0]), 0);
    for (int k = 0; k < 9; k++) send(0, 8'd10, 4'b0001);
    wait_out(0, 90, 0, -1, 0, 1'b0);

    // Fixed-schedule build: three GEN cycles per pair.
    basic_kernel(2);
    wait_out(2, 74, 0, 35, 0, 1'b0);
    for (int k = 0; k < 8; k++) send(2, 8'd5, 4'b0001);
    send(2, 8'd200, 4'b1000);
    wait_out(2, 40, 0, -1, 0, 1'b0);

    // Negative zero on the default build.
    for (int k = 0; k < 8; k++) send(0, 8'd3, 4'b1001);
    send(0, 8'd255, 4'b1000);
    wait_out(0, -24, 0, -1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
